station_issue_ctrl: RTL

Reservation-station controller that sequences one execution unit.
- Holds up to DEPTH dispatched instructions and captures missing operands from CDB broadcasts.
- Selects the oldest instruction whose operands are both ready and drives it into a registered issue stage.
- The issue stage feeds the exec side of the station/exec-unit link, with a valid/ready handshake.

---
 rtl/station_issue_ctrl_pkg.sv | 34 +++
 rtl/station_issue_ctrl_age_matrix.sv | 36 +++
 rtl/station_issue_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/station_issue_ctrl_pkg.sv
// station_issue_ctrl_pkg: shared widths, operation enum and entry/issue types for the reservation station
package station_issue_ctrl_pkg;
  localparam int XLEN = 32;
  localparam int RRN_W = 6;
  localparam int TAG_W = 7;
  typedef enum logic [3:0] {
    UNKNOWN, ADD, SUB, SLT, SLL, SRL, MUL, LOAD, STORE, BRANCH, JUMP
  } instr_name_e;
  typedef struct packed {
    logic valid;
    logic src1_rdy;
    logic src2_rdy;
    logic [RRN_W-1:0] src1_rrn;
    logic [RRN_W-1:0] src2_rrn;
    logic [XLEN-1:0] data_1;
    logic [XLEN-1:0] data_2;
    logic [XLEN-1:0] address;
    logic [XLEN-1:0] imm;
    logic [RRN_W-1:0] rrn;
    logic [TAG_W-1:0] tag;
    instr_name_e instr_name;
  } station_entry_t;
  typedef struct packed {
    logic [XLEN-1:0] data_1;
    logic [XLEN-1:0] data_2;
    logic [XLEN-1:0] address;
    logic [XLEN-1:0] imm;
    logic [RRN_W-1:0] rrn;
    logic [TAG_W-1:0] tag;
    instr_name_e instr_name;
  } issue_t;
  localparam station_entry_t ENTRY_RESET = '{instr_name: UNKNOWN, default: '0};
  localparam issue_t ISSUE_RESET = '{instr_name: UNKNOWN, default: '0};
endpackage

// File: rtl/station_issue_ctrl_age_matrix.sv
// station_age_matrix: older-than matrix picking the oldest ready entry combinationally from registered state
module station_age_matrix #(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DEPTH-1:0] alloc,
  input  logic [DEPTH-1:0] free,
  input  logic [DEPTH-1:0] cand,
  output logic [DEPTH-1:0] oldest
);
  logic [DEPTH-1:0] older_q [DEPTH];
  logic [DEPTH-1:0] older_d [DEPTH];
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      older_d[i] = free[i] ? '0 : older_q[i];
      older_d[i] = alloc[i] ? '0 : older_d[i] | alloc;
    end
  end
  always_comb begin
    oldest = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic hit;
      hit = 1'b0;
      for (int j = 0; j < DEPTH; j++) hit = hit | (cand[j] & older_q[j][i]);
      oldest[i] = cand[i] & ~hit;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) older_q[i] <= '0;
    end else begin
      older_q <= older_d;
    end
  end
endmodule

// File: rtl/station_issue_ctrl.sv
// station_issue_ctrl: reservation station with CDB wake-up, oldest-ready select and a registered issue stage
module station_issue_ctrl import station_issue_ctrl_pkg::*; #(
  parameter int XLEN = 32,
  parameter int DEPTH = 4,
  parameter int RRN_W = 6,
  parameter int TAG_W = 7
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN-1:0]            in_data_1,
  input  logic [XLEN-1:0]            in_data_2,
  input  logic                       in_src1_rdy,
  input  logic                       in_src2_rdy,
  input  logic [RRN_W-1:0]           in_src1_rrn,
  input  logic [RRN_W-1:0]           in_src2_rrn,
  input  logic [XLEN-1:0]            in_address,
  input  logic [XLEN-1:0]            in_imm,
  input  logic [RRN_W-1:0]           in_rrn,
  input  logic [TAG_W-1:0]           in_tag,
  input  instr_name_e                in_instr_name,
  input  logic                       cdb_valid,
  input  logic [RRN_W-1:0]           cdb_rrn,
  input  logic [XLEN-1:0]            cdb_data,
  output logic                       issue_valid,
  input  logic                       issue_ready,
  output logic [XLEN-1:0]            issue_data_1,
  output logic [XLEN-1:0]            issue_data_2,
  output logic [XLEN-1:0]            issue_address,
  output logic [XLEN-1:0]            issue_immediate,
  output logic [RRN_W-1:0]           issue_rrn,
  output logic [TAG_W-1:0]           issue_tag,
  output instr_name_e                issue_instr_name,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);
  localparam int OCC_W = $clog2(DEPTH+1);
  station_entry_t ent_q [DEPTH];
  station_entry_t ent_d [DEPTH];
  station_entry_t new_e;
  issue_t iss_q, iss_d, sel_i;
  logic iss_valid_q, iss_valid_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [DEPTH-1:0] valid, free, alloc_oh, cand, grant;
  logic alloc, fire, byp1, byp2;
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      valid[i] = ent_q[i].valid;
      cand[i] = ent_q[i].valid & ent_q[i].src1_rdy & ent_q[i].src2_rdy;
    end
    free = ~valid;
    alloc_oh = free & (~free + 1'b1);
  end
  assign in_ready = |free;
  assign alloc = in_valid & in_ready & ~flush;
  assign fire = (~iss_valid_q | issue_ready) & (|cand) & ~flush;
  station_age_matrix #(.DEPTH(DEPTH)) u_age (
    .clk    (clk),
    .rst_n  (rst_n),
    .alloc  (alloc ? alloc_oh : '0),
    .free   (fire ? grant : '0),
    .cand   (cand),
    .oldest (grant)
  );
  assign byp1 = cdb_valid & ~in_src1_rdy & (cdb_rrn == in_src1_rrn);
  assign byp2 = cdb_valid & ~in_src2_rdy & (cdb_rrn == in_src2_rrn);
  always_comb begin
    new_e = '{
      valid: 1'b1,
      src1_rdy: in_src1_rdy | byp1,
      src2_rdy: in_src2_rdy | byp2,
      src1_rrn: in_src1_rrn,
      src2_rrn: in_src2_rrn,
      data_1: byp1 ? cdb_data : in_data_1,
      data_2: byp2 ? cdb_data : in_data_2,
      address: in_address,
      imm: in_imm,
      rrn: in_rrn,
      tag: in_tag,
      instr_name: in_instr_name
    };
    sel_i = ISSUE_RESET;
    for (int i = 0; i < DEPTH; i++)
      if (grant[i])
        sel_i = '{
          data_1: ent_q[i].data_1,
          data_2: ent_q[i].data_2,
          address: ent_q[i].address,
          imm: ent_q[i].imm,
          rrn: ent_q[i].rrn,
          tag: ent_q[i].tag,
          instr_name: ent_q[i].instr_name
        };
  end
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      if (cdb_valid && ent_q[i].valid && !ent_q[i].src1_rdy && ent_q[i].src1_rrn == cdb_rrn) begin
        ent_d[i].src1_rdy = 1'b1;
        ent_d[i].data_1 = cdb_data;
      end
      if (cdb_valid && ent_q[i].valid && !ent_q[i].src2_rdy && ent_q[i].src2_rrn == cdb_rrn) begin
        ent_d[i].src2_rdy = 1'b1;
        ent_d[i].data_2 = cdb_data;
      end
      if (fire && grant[i]) ent_d[i].valid = 1'b0;
      if (alloc && alloc_oh[i]) ent_d[i] = new_e;
      if (flush) ent_d[i].valid = 1'b0;
    end
    iss_valid_d = flush ? 1'b0 : fire ? 1'b1 : issue_ready ? 1'b0 : iss_valid_q;
    iss_d = flush ? ISSUE_RESET : fire ? sel_i : iss_q;
    occ_d = flush ? '0 : occ_q + OCC_W'(alloc) - OCC_W'(fire);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ENTRY_RESET;
      iss_q <= ISSUE_RESET;
      iss_valid_q <= 1'b0;
      occ_q <= '0;
    end else begin
      ent_q <= ent_d;
      iss_q <= iss_d;
      iss_valid_q <= iss_valid_d;
      occ_q <= occ_d;
    end
  end
  assign issue_valid = iss_valid_q;
  assign issue_data_1 = iss_q.data_1;
  assign issue_data_2 = iss_q.data_2;
  assign issue_address = iss_q.address;
  assign issue_immediate = iss_q.imm;
  assign issue_rrn = iss_q.rrn;
  assign issue_tag = iss_q.tag;
  assign issue_instr_name = iss_q.instr_name;
  assign occupancy = occ_q;
endmodule
